// File: rtl/mult_pkg.sv
// mult_pkg: FSM states, Booth select codes and the step-count helper
package mult_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {SEL_ZERO, SEL_P1, SEL_P2, SEL_M2, SEL_M1} booth_sel_e;
  function automatic int mult_steps(int width);
    return width / 2 + 1;
  endfunction
  function automatic booth_sel_e booth_decode(logic [2:0] t);
    return (t == 3'b001 || t == 3'b010) ? SEL_P1 :
           (t == 3'b011)                 ? SEL_P2 :
           (t == 3'b100)                 ? SEL_M2 :
           (t == 3'b101 || t == 3'b110) ? SEL_M1 : SEL_ZERO;
  endfunction
endpackage

// File: rtl/booth_r4_select.sv
// booth_r4_select: signed radix-4 Booth addend for one multiplier bit triple
module booth_r4_select import mult_pkg::*; #(
  parameter int XW = 10
) (
  input  logic [2:0]    triple_i,
  input  logic [XW-1:0] mcand_i,
  output logic [XW-1:0] addend_o
);
  booth_sel_e sel;
  logic [XW-1:0] dbl;
  always_comb begin
    sel = booth_decode(triple_i);
    dbl = mcand_i << 1;
    addend_o = sel == SEL_P1 ? mcand_i :
               sel == SEL_P2 ? dbl :
               sel == SEL_M2 ? -dbl :
               sel == SEL_M1 ? -mcand_i : '0;
  end
endmodule

// File: rtl/radix4_multiplier.sv
// radix4_multiplier: sequential radix-4 Booth multiplier; MULT_OVERFLOW_FLAG_EN adds op_ovf
module radix4_multiplier import mult_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               op_busy,
  output logic               op_done,
`ifdef MULT_OVERFLOW_FLAG_EN
  output logic               op_ovf,
`endif
  output logic [2*WIDTH-1:0] result
);
  localparam int XW = WIDTH + 2;
  localparam int NSTEP = mult_steps(WIDTH);
  localparam int CW = $clog2(NSTEP);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] acc_q, m_q, mc_q, addend, sum, acc_d, m_d;
  logic lb_q, busy_q, done_q;
  logic [2*WIDTH-1:0] result_q, prod;
  function automatic logic [XW-1:0] ext(logic [WIDTH-1:0] v, logic s);
    return {{2{s & v[WIDTH-1]}}, v};
  endfunction
  booth_r4_select #(.XW(XW)) u_sel (
    .triple_i({m_q[1:0], lb_q}),
    .mcand_i (mc_q),
    .addend_o(addend)
  );
  // Partial sums never exceed 2|M|, so WIDTH+2 bits hold them without wrapping
  always_comb begin
    sum = acc_q + addend;
    acc_d = {{2{sum[XW-1]}}, sum[XW-1:2]};
    m_d = {sum[1:0], m_q[XW-1:2]};
    prod = {acc_d[WIDTH-3:0], m_d};
  end
`ifdef MULT_OVERFLOW_FLAG_EN
  logic sgn_q, ovf_q, ovf_d;
  always_comb ovf_d = sgn_q ? prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}} : |prod[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      sgn_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == BUSY) begin
      if (cnt_q == CW'(NSTEP - 1)) ovf_q <= ovf_d;
    end else if (op_start) begin
      sgn_q <= op_signed;
      ovf_q <= 1'b0;
    end
  end
  assign op_ovf = ovf_q;
`endif
  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      m_q      <= '0;
      mc_q     <= '0;
      lb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
      m_q   <= m_d;
      lb_q  <= m_q[1];
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(NSTEP - 1)) begin
        state_q  <= DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= prod;
      end
    end else if (op_start) begin
      state_q  <= BUSY;
      cnt_q    <= '0;
      acc_q    <= '0;
      lb_q     <= 1'b0;
      m_q      <= ext(multiplier, op_signed);
      mc_q     <= ext(multiplicand, op_signed);
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
    end
  end
  assign op_busy = busy_q;
  assign op_done = done_q;
  assign result  = result_q;
endmodule

// File: doc/radix4_multiplier.md
RADIX4_MULTIPLIER -- requirements
Module: radix4_multiplier

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_start  input  1  request to begin a multiply with the current operands.
REQ-005 op_clear  input  1  abort or clear; returns the block to idle.
REQ-006 op_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with op_start.
REQ-007 multiplier  input  WIDTH  multiplier operand.
REQ-008 multiplicand  input  WIDTH  multiplicand operand.
REQ-009 op_busy  output  1  high while iterating.
REQ-010 op_done  output  1  high while result is valid.
REQ-011 result  output  2*WIDTH  product.

Function
REQ-012 The block SHALL implement the FSM IDLE -> BUSY -> DONE.
REQ-013 Per-state outputs SHALL be: IDLE op_busy=0, op_done=0; BUSY op_busy=1, op_done=0; DONE op_busy=0, op_done=1.
REQ-014 Operands and op_signed SHALL be captured on the edge op_start=1 is accepted (IDLE or DONE); input changes afterwards SHALL be ignored until the next acceptance.
REQ-015 Internal operand width SHALL be WIDTH+2 bits: sign-extended when op_signed=1, zero-extended when 0.
REQ-016 Each BUSY cycle SHALL perform one radix-4 Booth step on bit triple {m[1], m[0], lastbit}: select 0, +M, +2M, -2M, -M or -M, 0 per the standard table, then arithmetic-shift {acc, m, lastbit} right by 2.
REQ-017 Step count SHALL be fixed at WIDTH/2+1 for both modes.
REQ-018 op_start accepted at edge k SHALL make op_done=1 after edge k+WIDTH/2+1; the last step and the move to DONE SHALL occur on the same edge.
REQ-019 result SHALL equal the exact 2*WIDTH-bit product, signed or unsigned per the captured mode, and SHALL hold while in DONE.
REQ-020 result is unspecified while op_busy=1.
REQ-021 result SHALL be 0 in IDLE.
REQ-022 op_start while BUSY SHALL be ignored.
REQ-023 op_start while DONE SHALL start a new operation (restart).
REQ-024 op_clear=1 in any state SHALL go to IDLE next edge, zeroing result and all internal registers.
REQ-025 op_clear SHALL take priority over simultaneous op_start.
REQ-026 Accumulator arithmetic SHALL be modulo 2^(WIDTH+2); no other saturation or exception states SHALL exist.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, op_busy=0, op_done=0, result=0 and clear the count, accumulator, lastbit and operand registers.
REQ-028 reset SHALL override op_start and op_clear, including when asserted mid-operation.

Configuration
REQ-029 With MULT_OVERFLOW_FLAG_EN defined, the block SHALL add output op_ovf (1 bit), valid while op_done=1.
REQ-030 op_ovf SHALL be 1 when the upper WIDTH bits of result are not the sign/zero extension of the lower WIDTH bits for the captured mode; it SHALL be 0 at reset, after clear, and whenever op_done=0.
REQ-031 Without MULT_OVERFLOW_FLAG_EN, the op_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package mult_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE), the Booth-select encoding, and a constant function giving the step count from WIDTH.
REQ-033 Sub-module booth_r4_select (combinational) SHALL take the bit triple and the extended multiplicand and produce the signed addend; the top level SHALL own the FSM, counter and shift registers.

Verification (WIDTH=8 unless noted)
REQ-034 Signed -128 x -128 -> op_done exactly 5 cycles after start, result=0x4000.
REQ-035 Unsigned 0xFF x 0xFF -> result=0xFE01; signed 0xFF x 0x01 -> result=0xFFFF.
REQ-036 Clear and start paths: op_clear at step 2 of an operation -> IDLE next edge, result=0, op_done=0; simultaneous op_start+op_clear -> stays IDLE.
REQ-037 Busy and restart: op_start pulses and operand changes while BUSY -> ignored, original product delivered; op_start in DONE -> new product after 5 more cycles.
REQ-038 MULT_OVERFLOW_FLAG_EN: signed 16 x 16 -> result=0x0100, op_ovf=1; signed 3 x -5 -> result=0xFFF1, op_ovf=0.
REQ-039 WIDTH=64 random signed and unsigned pairs plus reset mid-BUSY -> matches reference model; after reset, all outputs are 0.
